// File: rtl/mcp_pkg.sv
// Shared definitions for the MCP bus crossing: FSM encoding, ack timeout and sizing helpers.
package mcp_pkg;

    typedef enum logic [1:0] {
        MCP_IDLE   = 2'd0,
        MCP_LAUNCH = 2'd1,
        MCP_GAP    = 2'd2
    } mcp_state_e;

    // Cycles allowed per handshake phase before the launcher gives up.
    localparam int unsigned ACK_TIMEOUT = 64;

    function automatic int unsigned mcp_max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to represent values 0..v-1.
    function automatic int unsigned mcp_clog2(int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mcp_ack_sync.sv
// Flop-chain synchronizer bringing the destination ack level into the source clock domain.
// Built only when MCP_ACK_EN is defined.
`ifdef MCP_ACK_EN
module mcp_ack_sync #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [NUM_STAGES-1:0] sync_q;

    // Shift the async level in at the LSB; the MSB is the settled copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= NUM_STAGES'({sync_q, async_in});
        end
    end

    assign sync_out = sync_q[NUM_STAGES-1];

endmodule
`endif

// File: rtl/mcp_bus_launcher.sv
// Source-domain launcher of the multi-cycle-path bus crossing: holds a word, pulses a level
// enable for a fixed window, then guards the data. MCP_ACK_EN swaps fixed timing for a 4-phase ack.
module mcp_bus_launcher
    import mcp_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 8,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned NUM_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] data_in,
    input  logic                 data_valid,
    output logic                 ready,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 tx_done
`ifdef MCP_ACK_EN
    ,
    input  logic                 ack_async,
    output logic                 ack_timeout
`endif
);

    localparam int unsigned CNT_W = mcp_clog2(mcp_max3(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT) + 1);

    mcp_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 en_q, en_d;
    logic                 done_q, done_d;

`ifdef MCP_ACK_EN
    logic ack_s;
    logic to_q, to_d;

    mcp_ack_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ack_async),
        .sync_out (ack_s)
    );
`else
    logic unused_params;
    assign unused_params = ^32'(NUM_STAGES);
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MCP_IDLE;
            cnt_q   <= '0;
            bus_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef MCP_ACK_EN
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            done_q  <= done_d;
`ifdef MCP_ACK_EN
            to_q    <= to_d;
`endif
        end
    end

    // Next-state, counter and output decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        en_d    = en_q;
        done_d  = 1'b0;
`ifdef MCP_ACK_EN
        to_d    = to_q;
`endif
        case (state_q)
            MCP_IDLE: begin
                if (data_valid) begin
                    bus_d   = data_in;
                    en_d    = 1'b1;
                    state_d = MCP_LAUNCH;
`ifdef MCP_ACK_EN
                    cnt_d   = CNT_W'(ACK_TIMEOUT - 1);
`else
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
`endif
                end
            end
            MCP_LAUNCH: begin
`ifdef MCP_ACK_EN
                // Minimum hold is met once HOLD_CYCLES of the timeout window have elapsed.
                if (ack_s && (cnt_q <= CNT_W'(ACK_TIMEOUT - HOLD_CYCLES))) begin
                    en_d    = 1'b0;
                    cnt_d   = CNT_W'(ACK_TIMEOUT - 1);
                    state_d = MCP_GAP;
                end else if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    to_d    = 1'b1;
                    state_d = MCP_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`else
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    state_d = MCP_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            MCP_GAP: begin
`ifdef MCP_ACK_EN
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = MCP_IDLE;
                end else if (cnt_q == '0) begin
                    to_d    = 1'b1;
                    state_d = MCP_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`else
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = MCP_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            default: begin
                en_d    = 1'b0;
                state_d = MCP_IDLE;
            end
        endcase
    end

    assign ready      = (state_q == MCP_IDLE);
    assign unsync_bus = bus_q;
    assign bus_enable = en_q;
    assign tx_done    = done_q;
`ifdef MCP_ACK_EN
    assign ack_timeout = to_q;
`endif

endmodule

// File: tb/tb_mcp_bus_launcher.sv
// Self-checking bench for mcp_bus_launcher (default fixed-timing build) with a timing reference
// model and a slow destination-domain capture model.
module tb_mcp_bus_launcher;

    localparam int unsigned BW   = 8;
    localparam int          H    = 4;
    localparam int          G    = 4;
    localparam int          IDLE_AGE = 100000;

    logic          clk;
    logic          dclk;
    logic          rst;
    logic [BW-1:0] data_in;
    logic          data_valid;
    logic          ready;
    logic [BW-1:0] unsync_bus;
    logic          bus_enable;
    logic          tx_done;

    int errors;
    int checks;

    // Reference model: edges since the last accepted word, plus that word.
    int            age;
    logic [BW-1:0] mbus;

    logic [BW-1:0] cap_q[$];
    logic          s1, s2, s3;

    mcp_bus_launcher #(
        .BUS_WIDTH   (BW),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .NUM_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .ready      (ready),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable),
        .tx_done    (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Destination clock three times slower, offset from the source edges.
    initial begin
        dclk = 1'b0;
        #3;
        forever #15 dclk = ~dclk;
    end

    always @(posedge dclk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus_enable;
            s2 <= s1;
            s3 <= s2;
            if (s2 && !s3) cap_q.push_back(unsync_bus);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"},   32'(ready),      32'(age >= H + G));
        chk({tag, ".enable"},  32'(bus_enable), 32'(age < H));
        chk({tag, ".tx_done"}, 32'(tx_done),    32'(age == H + G));
        chk({tag, ".bus"},     32'(unsync_bus), 32'(mbus));
    endtask

    // One source clock: predict from pre-edge inputs, advance, then sample 1ns after the edge.
    task automatic tick(input string tag);
        logic          acc;
        logic [BW-1:0] d;
        acc = rst && data_valid && (age >= H + G);
        d   = data_in;
        @(posedge clk);
        if (!rst) begin
            age  = IDLE_AGE;
            mbus = '0;
        end else if (acc) begin
            age  = 0;
            mbus = d;
        end else if (age < IDLE_AGE) begin
            age = age + 1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [BW-1:0] c0, c1;
        errors     = 0;
        checks     = 0;
        age        = IDLE_AGE;
        mbus       = '0;
        rst        = 1'b0;
        data_valid = 1'b1;
        data_in    = 8'hFF;

        // Reset held with valid asserted: nothing may launch.
        repeat (3) tick("reset");
        chk("reset.ready_const", 32'(ready), 32'd1);
        chk("reset.bus_const",   32'(unsync_bus), 32'd0);
        data_valid = 1'b0;
        rst = 1'b1;
        tick("post_reset");

        // Single word.
        data_in    = 8'hA5;
        data_valid = 1'b1;
        tick("single");
        data_valid = 1'b0;
        repeat (10) tick("single");

        // Back-to-back with valid held; second accept lands on the tx_done cycle.
        cap_q.delete();
        data_in    = 8'h11;
        data_valid = 1'b1;
        tick("b2b");
        data_in = 8'h22;
        repeat (9) tick("b2b");
        data_valid = 1'b0;
        repeat (20) tick("b2b");
        c0 = (cap_q.size() > 0) ? cap_q[0] : 8'hEE;
        c1 = (cap_q.size() > 1) ? cap_q[1] : 8'hEE;
        chk("b2b.dest_count", 32'(cap_q.size()), 32'd2);
        chk("b2b.dest_word0", 32'(c0), 32'h11);
        chk("b2b.dest_word1", 32'(c1), 32'h22);

        // Data toggling while busy must not leak onto the bus.
        data_in    = 8'h5A;
        data_valid = 1'b1;
        tick("toggle");
        data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data_in = ~data_in;
            tick("toggle");
        end

        // Asynchronous reset during LAUNCH.
        data_in    = 8'hC3;
        data_valid = 1'b1;
        tick("areset");
        data_valid = 1'b0;
        tick("areset");
        #3;
        rst  = 1'b0;
        age  = IDLE_AGE;
        mbus = '0;
        #1;
        chk("areset.enable_now", 32'(bus_enable), 32'd0);
        chk("areset.bus_now",    32'(unsync_bus), 32'd0);
        chk("areset.ready_now",  32'(ready),      32'd1);
        chk("areset.done_now",   32'(tx_done),    32'd0);
        repeat (2) tick("areset_hold");
        rst        = 1'b1;
        data_in    = 8'h3C;
        data_valid = 1'b1;
        tick("after_reset");
        data_valid = 1'b0;
        repeat (10) tick("after_reset");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            data_valid = ($urandom_range(0, 2) == 0);
            data_in    = BW'($urandom);
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
